// File: rtl/ga_cfg_seq.sv
// rtl/ga_cfg_seq.sv - GA core configuration register block and start sequencer
//
// Purpose: holds shadow configuration registers for the GA core, checks them
// on a start command, applies them to the core outputs and raises ga_enable
// after a fixed start-up delay.
//
// Ports:
//    clk             clock
//    rstn            asynchronous active-low reset
//    reg_wr          register write strobe (single cycle)
//    reg_rd          register read strobe (single cycle)
//    reg_addr        register address
//    reg_wdata       write data
//    reg_rdata       registered read data, valid with reg_rvalid
//    reg_rvalid      read data valid pulse, one cycle after reg_rd
//    inputs_counter  sample count from the GA core, readable at address 6
//    ga_enable       GA core enable
//    cnfg_m/p/b/g    applied configuration, frozen outside CHECK->DELAY
//    cfg_err         sticky illegal-configuration flag

module ga_cfg_seq #(
   parameter int M_MAX     = 8,
   parameter int M_MAX_W   = 4,
   parameter int P_MAX_W   = 6,
   parameter int B_MAX_W   = 6,
   parameter int G_MAX_W   = 16,
   parameter int START_DLY = 9,
   parameter int AUTOSTART = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               reg_wr,
   input  logic               reg_rd,
   input  logic [2:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic               reg_rvalid,
   input  logic [31:0]        inputs_counter,
   output logic               ga_enable,
   output logic [M_MAX_W-1:0] cnfg_m,
   output logic [P_MAX_W-1:0] cnfg_p,
   output logic [B_MAX_W-1:0] cnfg_b,
   output logic [G_MAX_W-1:0] cnfg_g,
   output logic               cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_DELAY = 3'd2,
      S_RUN   = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam int CNT_W = $clog2(START_DLY + 1);
   localparam logic [CNT_W-1:0] LP_DLY_LAST = CNT_W'(START_DLY - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_dly_cnt;
   logic [3:0]         r_err_code;
   logic               r_boot;
   logic [M_MAX_W-1:0] r_m;
   logic [P_MAX_W-1:0] r_p;
   logic [B_MAX_W-1:0] r_b;
   logic [G_MAX_W-1:0] r_g;

   logic               w_ctrl_wr;
   logic               w_stop;
   logic               w_go;
   logic [3:0]         w_err;
   logic [31:0]        w_rd_data;
   logic               w_unused;

   // Only the low bits of each shadow write are stored.
   assign w_unused = ^reg_wdata;

   assign w_ctrl_wr = reg_wr && (reg_addr == 3'd0);
   assign w_stop    = w_ctrl_wr && reg_wdata[1];
   // r_boot is high only on the first edge after reset release, so with
   // AUTOSTART it acts as a one-shot start command. Stop always wins.
   assign w_go      = ((w_ctrl_wr && reg_wdata[0]) || (r_boot && (AUTOSTART != 0)))
                      && !w_stop;

   assign w_err[0] = (r_m == '0) || (32'(r_m) > 32'(M_MAX));
   assign w_err[1] = (32'(r_p) < 32'd2) || r_p[0];
   assign w_err[2] = (r_b == '0) || (32'(r_b) > 32'(r_p));
   assign w_err[3] = (r_g == '0);

   always_comb begin
      w_rd_data = 32'd0;
      case (reg_addr)
         3'd1:    w_rd_data = 32'(r_m);
         3'd2:    w_rd_data = 32'(r_p);
         3'd3:    w_rd_data = 32'(r_b);
         3'd4:    w_rd_data = 32'(r_g);
         3'd5:    w_rd_data = {24'd0, r_err_code, cfg_err, r_state};
         3'd6:    w_rd_data = inputs_counter;
         default: w_rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_dly_cnt  <= '0;
         r_err_code <= 4'd0;
         r_boot     <= 1'b1;
         r_m        <= M_MAX_W'(7);
         r_p        <= P_MAX_W'(16);
         r_b        <= B_MAX_W'(16);
         r_g        <= G_MAX_W'(10);
         reg_rdata  <= 32'd0;
         reg_rvalid <= 1'b0;
         ga_enable  <= 1'b0;
         cnfg_m     <= '0;
         cnfg_p     <= '0;
         cnfg_b     <= '0;
         cnfg_g     <= '0;
         cfg_err    <= 1'b0;
      end else begin
         r_boot     <= 1'b0;
         reg_rvalid <= reg_rd;
         // Read samples the current register values, so a write to the
         // same address in the same cycle returns the old contents.
         if (reg_rd) begin
            reg_rdata <= w_rd_data;
         end

         if (reg_wr) begin
            case (reg_addr)
               3'd1:    r_m <= reg_wdata[M_MAX_W-1:0];
               3'd2:    r_p <= reg_wdata[P_MAX_W-1:0];
               3'd3:    r_b <= reg_wdata[B_MAX_W-1:0];
               3'd4:    r_g <= reg_wdata[G_MAX_W-1:0];
               default: ;
            endcase
         end

         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_stop) begin
                  r_state <= S_IDLE;
               end else if (w_err == 4'd0) begin
                  r_state    <= S_DELAY;
                  r_dly_cnt  <= '0;
                  r_err_code <= 4'd0;
                  cnfg_m     <= r_m;
                  cnfg_p     <= r_p;
                  cnfg_b     <= r_b;
                  cnfg_g     <= r_g;
               end else begin
                  r_state    <= S_ERR;
                  r_err_code <= w_err;
                  cfg_err    <= 1'b1;
               end
            end
            S_DELAY: begin
               if (w_stop) begin
                  r_state <= S_IDLE;
               end else if (r_dly_cnt == LP_DLY_LAST) begin
                  r_state   <= S_RUN;
                  ga_enable <= 1'b1;
               end else begin
                  r_dly_cnt <= r_dly_cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (w_stop) begin
                  r_state   <= S_IDLE;
                  ga_enable <= 1'b0;
               end
            end
            S_ERR: begin
               if (w_stop) begin
                  r_state    <= S_IDLE;
                  cfg_err    <= 1'b0;
                  r_err_code <= 4'd0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               ga_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ga_cfg_seq.sv
// tb/tb_ga_cfg_seq.sv - directed self-checking bench for ga_cfg_seq

module tb_ga_cfg_seq;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        reg_wr = 1'b0;
   logic        reg_rd = 1'b0;
   logic [2:0]  reg_addr = 3'd0;
   logic [31:0] reg_wdata = 32'd0;
   logic [31:0] inputs_counter = 32'd0;

   logic [31:0] a_rdata, b_rdata;
   logic        a_rvalid, b_rvalid;
   logic        a_ga, b_ga;
   logic [3:0]  a_m, b_m;
   logic [5:0]  a_p, b_p, a_b, b_b;
   logic [15:0] a_g, b_g;
   logic        a_err, b_err;

   int n_checks = 0;
   int n_fail   = 0;

   ga_cfg_seq #(.AUTOSTART(1)) u_dut (
      .clk(clk), .rstn(rstn), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(a_rdata), .reg_rvalid(a_rvalid),
      .inputs_counter(inputs_counter), .ga_enable(a_ga), .cnfg_m(a_m), .cnfg_p(a_p),
      .cnfg_b(a_b), .cnfg_g(a_g), .cfg_err(a_err)
   );

   ga_cfg_seq #(.AUTOSTART(0)) u_dut0 (
      .clk(clk), .rstn(rstn), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(b_rdata), .reg_rvalid(b_rvalid),
      .inputs_counter(inputs_counter), .ga_enable(b_ga), .cnfg_m(b_m), .cnfg_p(b_p),
      .cnfg_b(b_b), .cnfg_g(b_g), .cfg_err(b_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v);
      reg_rd = 1'b1; reg_addr = a;
      tick();
      reg_rd = 1'b0;
      d = a_rdata; v = a_rvalid;
   endtask

   // Called right after the DELAY entry edge; ga_enable must rise exactly 9 edges later.
   task automatic wait_run(input string name);
      int n = 0;
      while (a_ga !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      n_checks++; if (n != 9) begin n_fail++; $display("FAIL %s delay_cycles got %0d exp 9", name, n); end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (a_ga !== 1'b0) begin n_fail++; $display("FAIL reset_ga got %b exp 0", a_ga); end
      n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", a_err); end
      n_checks++; if ({a_m, a_p, a_b, a_g} !== 32'd0) begin n_fail++; $display("FAIL reset_cnfg got %h exp 0", {a_m, a_p, a_b, a_g}); end
      n_checks++; if ({a_rvalid, a_rdata} !== 33'd0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", {a_rvalid, a_rdata}); end
   endtask

   task automatic test_autostart();
      logic [31:0] d; logic v;
      rstn = 1'b1;
      tick();
      n_checks++; if ({a_ga, a_m} !== 5'd0) begin n_fail++; $display("FAIL auto_check got %h exp 0", {a_ga, a_m}); end
      tick();
      n_checks++; if ({a_m, a_p, a_b, a_g} !== {4'd7, 6'd16, 6'd16, 16'd10}) begin n_fail++; $display("FAIL auto_cnfg got %h exp %h", {a_m, a_p, a_b, a_g}, {4'd7, 6'd16, 6'd16, 16'd10}); end
      wait_run("auto");
      n_checks++; if ({b_ga, b_m} !== 5'd0) begin n_fail++; $display("FAIL noauto_idle got %h exp 0", {b_ga, b_m}); end
      rd(3'd5, d, v);
      n_checks++; if ({v, d} !== {1'b1, 32'h3}) begin n_fail++; $display("FAIL auto_status got %h exp 100000003", {v, d}); end
      n_checks++; if (b_rdata !== 32'h0) begin n_fail++; $display("FAIL noauto_status got %h exp 0", b_rdata); end
      repeat (5) tick();
      n_checks++; if (a_ga !== 1'b1) begin n_fail++; $display("FAIL auto_hold got %b exp 1", a_ga); end
   endtask

   task automatic test_err_single();
      logic [31:0] d; logic v;
      wr(3'd0, 32'h2);
      n_checks++; if (a_ga !== 1'b0) begin n_fail++; $display("FAIL stop_run_ga got %b exp 0", a_ga); end
      wr(3'd1, 32'd9);
      wr(3'd0, 32'h1);
      tick();
      n_checks++; if ({a_err, a_ga, b_err} !== 3'b101) begin n_fail++; $display("FAIL err_m_flags got %b exp 101", {a_err, a_ga, b_err}); end
      rd(3'd5, d, v);
      n_checks++; if (d !== 32'h1C) begin n_fail++; $display("FAIL err_m_status got %h exp 1c", d); end
      wr(3'd0, 32'h1);
      tick();
      n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL err_start_ignored got %b exp 1", a_err); end
      wr(3'd0, 32'h2);
      n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", a_err); end
      rd(3'd5, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL err_clear_status got %h exp 0", d); end
   endtask

   task automatic test_err_all();
      logic [31:0] d; logic v;
      wr(3'd2, 32'd15); wr(3'd3, 32'd20); wr(3'd4, 32'd0); wr(3'd1, 32'd0);
      wr(3'd0, 32'h1);
      tick();
      n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL err_all_flag got %b exp 1", a_err); end
      rd(3'd5, d, v);
      n_checks++; if (d !== 32'hFC) begin n_fail++; $display("FAIL err_all_status got %h exp fc", d); end
      wr(3'd0, 32'h2);
      wr(3'd1, 32'hFFFF_FFF8); wr(3'd2, 32'd8); wr(3'd3, 32'd8); wr(3'd4, 32'd100);
      rd(3'd1, d, v);
      n_checks++; if (d !== 32'd8) begin n_fail++; $display("FAIL shadow_m_mask got %h exp 8", d); end
      wr(3'd0, 32'h1);
      tick();
      n_checks++; if ({a_m, a_p, a_b, a_g, a_err} !== {4'd8, 6'd8, 6'd8, 16'd100, 1'b0}) begin n_fail++; $display("FAIL legal_cnfg got %h exp %h", {a_m, a_p, a_b, a_g, a_err}, {4'd8, 6'd8, 6'd8, 16'd100, 1'b0}); end
      wait_run("legal");
   endtask

   task automatic test_run_shadow();
      logic [31:0] d; logic v;
      wr(3'd1, 32'd3);
      tick();
      n_checks++; if (a_m !== 4'd8) begin n_fail++; $display("FAIL run_frozen got %h exp 8", a_m); end
      rd(3'd1, d, v);
      n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL run_shadow got %h exp 3", d); end
      wr(3'd0, 32'h2);
      n_checks++; if ({a_ga, a_m} !== 5'h08) begin n_fail++; $display("FAIL stop_keep got %h exp 08", {a_ga, a_m}); end
      wr(3'd0, 32'h1);
      n_checks++; if (a_m !== 4'd8) begin n_fail++; $display("FAIL check_old_m got %h exp 8", a_m); end
      tick();
      n_checks++; if (a_m !== 4'd3) begin n_fail++; $display("FAIL restart_m got %h exp 3", a_m); end
      wait_run("restart");
   endtask

   task automatic test_ctrl_edge();
      logic [31:0] d; logic v;
      int seen;
      wr(3'd0, 32'h1);
      n_checks++; if (a_ga !== 1'b1) begin n_fail++; $display("FAIL start_in_run got %b exp 1", a_ga); end
      wr(3'd0, 32'h3);
      n_checks++; if (a_ga !== 1'b0) begin n_fail++; $display("FAIL stop_wins got %b exp 0", a_ga); end
      wr(3'd0, 32'h3);
      tick();
      rd(3'd5, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL both_idle got %h exp 0", d); end
      wr(3'd0, 32'h1);
      tick();
      repeat (3) tick();
      wr(3'd0, 32'h2);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (a_ga === 1'b1) seen++;
         tick();
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL delay_stop_ga got %0d exp 0", seen); end
      rd(3'd5, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL delay_stop_state got %h exp 0", d); end
      wr(3'd0, 32'h1);
      tick();
      wait_run("pre_reset");
      rd(3'd2, d, v);
      n_checks++; if ({v, d} !== {1'b1, 32'd8}) begin n_fail++; $display("FAIL read_p got %h exp 100000008", {v, d}); end
      rstn = 1'b0;
      #2;
      n_checks++; if ({a_ga, a_err, a_m, a_p, a_b, a_g} !== 34'd0) begin n_fail++; $display("FAIL async_rst_out got %h exp 0", {a_ga, a_err, a_m, a_p, a_b, a_g}); end
      n_checks++; if ({a_rvalid, a_rdata} !== 33'd0) begin n_fail++; $display("FAIL async_rst_rd got %h exp 0", {a_rvalid, a_rdata}); end
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_reads();
      logic [31:0] d; logic v;
      inputs_counter = 32'hDEADBEEF;
      rd(3'd6, d, v);
      n_checks++; if ({v, d} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL read_cnt got %h exp 1deadbeef", {v, d}); end
      tick();
      n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got %b exp 0", a_rvalid); end
      wr(3'd7, 32'h1234);
      rd(3'd7, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL read_7 got %h exp 0", d); end
      rd(3'd0, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL read_ctrl got %h exp 0", d); end
      rd(3'd2, d, v);
      n_checks++; if (d !== 32'd16) begin n_fail++; $display("FAIL rst_shadow_p got %h exp 10", d); end
      rd(3'd4, d, v);
      n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL rst_shadow_g got %h exp a", d); end
      reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 3'd1; reg_wdata = 32'd9;
      tick();
      reg_wr = 1'b0; reg_rd = 1'b0;
      n_checks++; if ({a_rvalid, a_rdata} !== {1'b1, 32'd7}) begin n_fail++; $display("FAIL rd_wr_same got %h exp 100000007", {a_rvalid, a_rdata}); end
      rd(3'd1, d, v);
      n_checks++; if (d !== 32'd9) begin n_fail++; $display("FAIL rd_after_wr got %h exp 9", d); end
      n_checks++; if (a_m !== 4'd7) begin n_fail++; $display("FAIL cnfg_after_rst got %h exp 7", a_m); end
   endtask

   initial begin
      test_reset();
      test_autostart();
      test_err_single();
      test_err_all();
      test_run_shadow();
      test_ctrl_edge();
      test_reads();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
